rtc_bus_responder: RTL and testbench

- Responder (slave) end of the multiplexed address/data parallel bus that our timing counter and control FSM drive toward the RTC.
- Decodes cs_n / rd_n / wr_n / ad_sel strobes, latches the register address, and serves writes and reads from an internal register file.
- Used as an on-chip RTC stand-in for board bring-up and as the bus model in system benches.
- Exposes a local read port and completion/error pulses to the surrounding logic.

---
 rtl/rtc_bus_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_responder.sv
// Responder end of the multiplexed AD bus toward the RTC. Synchronizes the bus
// strobes, decodes address/data/read phases and serves them from a register file.
module rtc_bus_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     ad_sel,
  input  logic [DATA_W-1:0]        ad_in,
  output logic [DATA_W-1:0]        ad_out,
  output logic                     ad_oe,
  input  logic [$clog2(DEPTH)-1:0] loc_addr,
  output logic [DATA_W-1:0]        loc_data,
  output logic                     wr_done,
  output logic                     rd_done,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEL  = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;

  // Strobe vector layout: {cs_n, rd_n, wr_n, ad_sel}
  localparam int B_CS  = 3;
  localparam int B_RD  = 2;
  localparam int B_WR  = 1;
  localparam int B_SEL = 0;

  logic [3:0]        sync1_d, sync1_q;
  logic [3:0]        sync2_d, sync2_q;
  logic [3:1]        sync3_d, sync3_q;
  logic              coll_d, coll_q;
  logic [1:0]        state_d, state_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic              addr_valid_d, addr_valid_q;
  logic [DATA_W-1:0] ad_out_d, ad_out_q;
  logic              ad_oe_d, ad_oe_q;
  logic              wr_done_d, wr_done_q;
  logic              rd_done_d, rd_done_q;
  logic              proto_err_d, proto_err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              cs_now_s, rd_now_s, wr_now_s, sel_now_s;
  logic              cs_fall_s, cs_rise_s, rd_fall_s, rd_rise_s, wr_fall_s, wr_rise_s;
  logic              both_low_s, both_low_prev_s, coll_onset_s, blocked_s;
  logic              in_range_s;
  logic [DATA_W-1:0] mem_rd_s;
  logic              mem_we_s;

  assign cs_now_s  = sync2_q[B_CS];
  assign rd_now_s  = sync2_q[B_RD];
  assign wr_now_s  = sync2_q[B_WR];
  assign sel_now_s = sync2_q[B_SEL];

  assign cs_fall_s = ~cs_now_s &  sync3_q[B_CS];
  assign cs_rise_s =  cs_now_s & ~sync3_q[B_CS];
  assign rd_fall_s = ~rd_now_s &  sync3_q[B_RD];
  assign rd_rise_s =  rd_now_s & ~sync3_q[B_RD];
  assign wr_fall_s = ~wr_now_s &  sync3_q[B_WR];
  assign wr_rise_s =  wr_now_s & ~sync3_q[B_WR];

  // A collision lasts until both strobes are high again, so the releasing edges are ignored too
  assign both_low_s      = ~rd_now_s & ~wr_now_s;
  assign both_low_prev_s = ~sync3_q[B_RD] & ~sync3_q[B_WR];
  assign coll_onset_s    = both_low_s & ~both_low_prev_s;
  assign blocked_s       = both_low_s | coll_q;

  assign in_range_s = {1'b0, addr_q} < DEPTH_EXT;
  assign mem_rd_s   = mem_q[addr_q[AW-1:0]];

  // Synchronizer chain plus the edge-detect stage
  always_comb begin
    sync1_d = {cs_n, rd_n, wr_n, ad_sel};
    sync2_d = sync1_q;
    sync3_d = sync2_q[3:1];
  end

  // Collision tracking
  always_comb begin
    coll_d = coll_q;
    if (both_low_s) begin
      coll_d = 1'b1;
    end else if (rd_now_s && wr_now_s) begin
      coll_d = 1'b0;
    end else begin
      coll_d = coll_q;
    end
  end

  // Protocol FSM: next state, address latch, read capture and status pulses
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    ad_out_d     = ad_out_q;
    ad_oe_d      = (state_q == ST_READ);
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    proto_err_d  = 1'b0;
    mem_we_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d = ST_SEL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SEL: begin
        if (coll_onset_s) begin
          proto_err_d = 1'b1;
        end else begin
          proto_err_d = 1'b0;
        end

        if (wr_rise_s && !blocked_s) begin
          if (!sel_now_s) begin
            addr_d       = ad_in;
            addr_valid_d = 1'b1;
          end else if (addr_valid_q) begin
            mem_we_s  = in_range_s;
            wr_done_d = 1'b1;
          end else begin
            proto_err_d = 1'b1;
          end
        end else begin
          mem_we_s = 1'b0;
        end

        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else if (rd_fall_s && !blocked_s) begin
          if (sel_now_s) begin
            state_d  = ST_READ;
            ad_out_d = (addr_valid_q && in_range_s) ? mem_rd_s : '0;
          end else begin
            proto_err_d = 1'b1;
          end
        end else begin
          state_d = ST_SEL;
        end
      end

      ST_READ: begin
        if (wr_fall_s || coll_onset_s) begin
          proto_err_d = 1'b1;
          ad_oe_d     = 1'b0;
          state_d     = cs_now_s ? ST_IDLE : ST_SEL;
        end else if (rd_rise_s || cs_rise_s) begin
          rd_done_d = 1'b1;
          ad_oe_d   = 1'b0;
          state_d   = cs_now_s ? ST_IDLE : ST_SEL;
        end else begin
          state_d = ST_READ;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ad_oe_d = 1'b0;
      end
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 4'b1110;
      sync2_q      <= 4'b1110;
      sync3_q      <= 3'b111;
      coll_q       <= 1'b0;
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      ad_out_q     <= '0;
      ad_oe_q      <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync3_q      <= sync3_d;
      coll_q       <= coll_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Register file
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_q[addr_q[AW-1:0]] <= ad_in;
    end
  end

  assign loc_data  = mem_q[loc_addr];
  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign wr_done   = wr_done_q;
  assign rd_done   = rd_done_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder: bus phases are driven on the pins and
// outputs are checked against hand-derived values, including strobe latency.
module tb_rtc_bus_responder;

  logic       clk;
  logic       reset;
  logic       cs_n, rd_n, wr_n, ad_sel;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [5:0] loc_addr;
  logic [7:0] loc_data;
  logic       wr_done, rd_done, proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  int wr_cnt = 0, rd_cnt = 0, pe_cnt = 0;
  int stretch_cnt = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0, pe_prev = 1'b0;

  rtc_bus_responder #(.DATA_W(8), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .ad_sel(ad_sel), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .loc_addr(loc_addr), .loc_data(loc_data), .wr_done(wr_done),
    .rd_done(rd_done), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counting and width monitoring away from the active edge
  always @(negedge clk) begin
    if (wr_done)   wr_cnt = wr_cnt + 1;
    if (rd_done)   rd_cnt = rd_cnt + 1;
    if (proto_err) pe_cnt = pe_cnt + 1;
    if ((wr_done && wr_prev) || (rd_done && rd_prev) || (proto_err && pe_prev))
      stretch_cnt = stretch_cnt + 1;
    wr_prev = wr_done;
    rd_prev = rd_done;
    pe_prev = proto_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_addr(input logic [7:0] a);
    ad_sel = 1'b0; ad_in = a; cs_n = 1'b0; tick(5);
    wr_n = 1'b0; tick(5);
    wr_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
  endtask

  task automatic bus_write(input logic [7:0] d);
    ad_sel = 1'b1; ad_in = d; cs_n = 1'b0; tick(5);
    wr_n = 1'b0; tick(5);
    wr_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
  endtask

  task automatic peek(input logic [5:0] a, output logic [7:0] v);
    loc_addr = a; #1;
    v = loc_data;
  endtask

  task automatic count_nonzero(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      loc_addr = 6'(i); #1;
      if (loc_data !== 8'h00) n = n + 1;
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    ad_sel = 1'b0; ad_in = 8'h00; loc_addr = 6'h00;
    tick(4);
    reset = 1'b0;
    tick(2);
    n_tests++;
    if (ad_oe !== 1'b0) begin $display("FAIL reset_ad_oe: got %b want 0", ad_oe); n_fail++; end
    n_tests++;
    if (ad_out !== 8'h00) begin $display("FAIL reset_ad_out: got %h want 00", ad_out); n_fail++; end
    n_tests++;
    if ({wr_done, rd_done, proto_err} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b want 000", {wr_done, rd_done, proto_err}); n_fail++;
    end
    peek(6'h21, v);
    n_tests++;
    if (v !== 8'h00) begin $display("FAIL reset_reg21: got %h want 00", v); n_fail++; end
  endtask

  task automatic test_write_no_addr;
    int w0, p0, nz;
    w0 = wr_cnt; p0 = pe_cnt;
    bus_write(8'h33);
    count_nonzero(nz);
    n_tests++;
    if (pe_cnt - p0 !== 1) begin $display("FAIL noaddr_proto: got %0d pulses want 1", pe_cnt - p0); n_fail++; end
    n_tests++;
    if (wr_cnt - w0 !== 0) begin $display("FAIL noaddr_wr_done: got %0d pulses want 0", wr_cnt - w0); n_fail++; end
    n_tests++;
    if (nz !== 0) begin $display("FAIL noaddr_regs: got %0d nonzero want 0", nz); n_fail++; end
  endtask

  task automatic test_write_read;
    int w0, r0, p0;
    logic [7:0] v;
    w0 = wr_cnt; p0 = pe_cnt;
    bus_addr(8'h21);
    ad_sel = 1'b1; ad_in = 8'h59; cs_n = 1'b0; loc_addr = 6'h21; tick(5);
    wr_n = 1'b0; tick(5);
    wr_n = 1'b1; tick(2);
    n_tests++;
    if (loc_data !== 8'h00) begin $display("FAIL wr_early: got %h want 00", loc_data); n_fail++; end
    tick(1);
    n_tests++;
    if (loc_data !== 8'h59 || wr_done !== 1'b1) begin
      $display("FAIL wr_commit: got data %h wr_done %b want 59 1", loc_data, wr_done); n_fail++;
    end
    tick(4);
    cs_n = 1'b1; tick(5);
    n_tests++;
    if (wr_cnt - w0 !== 1 || pe_cnt - p0 !== 0) begin
      $display("FAIL wr_pulses: got wr %0d pe %0d want 1 0", wr_cnt - w0, pe_cnt - p0); n_fail++;
    end
    peek(6'h21, v);
    n_tests++;
    if (v !== 8'h59) begin $display("FAIL wr_loc_data: got %h want 59", v); n_fail++; end

    r0 = rd_cnt;
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(3);
    n_tests++;
    if (ad_oe !== 1'b0) begin $display("FAIL rd_oe_early: got %b want 0", ad_oe); n_fail++; end
    tick(1);
    n_tests++;
    if (ad_oe !== 1'b1 || ad_out !== 8'h59) begin
      $display("FAIL rd_oe_on: got oe %b out %h want 1 59", ad_oe, ad_out); n_fail++;
    end
    tick(55);
    n_tests++;
    if (ad_oe !== 1'b1 || ad_out !== 8'h59) begin
      $display("FAIL rd_hold: got oe %b out %h want 1 59", ad_oe, ad_out); n_fail++;
    end
    rd_n = 1'b1; tick(5);
    n_tests++;
    if (ad_oe !== 1'b0 || rd_cnt - r0 !== 1) begin
      $display("FAIL rd_end: got oe %b rd_done %0d want 0 1", ad_oe, rd_cnt - r0); n_fail++;
    end
    cs_n = 1'b1; tick(5);
  endtask

  task automatic test_wr_in_read;
    int w0, p0;
    logic [7:0] v;
    w0 = wr_cnt; p0 = pe_cnt;
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(6);
    ad_in = 8'hC3; wr_n = 1'b0; tick(3);
    n_tests++;
    if (ad_oe !== 1'b0) begin $display("FAIL wrinrd_oe: got %b want 0", ad_oe); n_fail++; end
    tick(3);
    wr_n = 1'b1; tick(5);
    rd_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
    peek(6'h21, v);
    n_tests++;
    if (pe_cnt - p0 !== 1 || wr_cnt - w0 !== 0 || v !== 8'h59) begin
      $display("FAIL wrinrd_effect: got pe %0d wr %0d reg %h want 1 0 59", pe_cnt - p0, wr_cnt - w0, v);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    int w0;
    logic [7:0] v5, v3f;
    w0 = wr_cnt;
    bus_addr(8'h05); bus_write(8'h11);
    bus_addr(8'h3F); bus_write(8'hEE);
    peek(6'h05, v5);
    peek(6'h3F, v3f);
    n_tests++;
    if (wr_cnt - w0 !== 2 || v5 !== 8'h11 || v3f !== 8'hEE) begin
      $display("FAIL b2b_write: got wr %0d r05 %h r3f %h want 2 11 ee", wr_cnt - w0, v5, v3f); n_fail++;
    end
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(5);
    n_tests++;
    if (ad_oe !== 1'b1 || ad_out !== 8'hEE) begin
      $display("FAIL b2b_read: got oe %b out %h want 1 ee", ad_oe, ad_out); n_fail++;
    end
    rd_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
  endtask

  task automatic test_out_of_range;
    int w0, p0, nz;
    logic [7:0] v10;
    w0 = wr_cnt; p0 = pe_cnt;
    bus_addr(8'h50); bus_write(8'hAA);
    count_nonzero(nz);
    peek(6'h10, v10);
    n_tests++;
    if (wr_cnt - w0 !== 1 || pe_cnt - p0 !== 0) begin
      $display("FAIL oor_pulses: got wr %0d pe %0d want 1 0", wr_cnt - w0, pe_cnt - p0); n_fail++;
    end
    n_tests++;
    if (nz !== 3 || v10 !== 8'h00) begin
      $display("FAIL oor_regs: got %0d nonzero r10 %h want 3 00", nz, v10); n_fail++;
    end
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(5);
    n_tests++;
    if (ad_oe !== 1'b1 || ad_out !== 8'h00) begin
      $display("FAIL oor_read: got oe %b out %h want 1 00", ad_oe, ad_out); n_fail++;
    end
    rd_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
  endtask

  task automatic test_cs_release_mid_read;
    int r0;
    bus_addr(8'h21);
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(5);
    n_tests++;
    if (ad_oe !== 1'b1 || ad_out !== 8'h59) begin
      $display("FAIL csrel_read: got oe %b out %h want 1 59", ad_oe, ad_out); n_fail++;
    end
    r0 = rd_cnt;
    cs_n = 1'b1; tick(4);
    n_tests++;
    if (ad_oe !== 1'b0 || rd_cnt - r0 !== 1) begin
      $display("FAIL csrel_drop: got oe %b rd_done %0d want 0 1", ad_oe, rd_cnt - r0); n_fail++;
    end
    tick(3);
    rd_n = 1'b1; tick(6);
    rd_n = 1'b0; tick(6);
    n_tests++;
    if (rd_cnt - r0 !== 1 || ad_oe !== 1'b0) begin
      $display("FAIL csrel_idle: got rd_done %0d oe %b want 1 0", rd_cnt - r0, ad_oe); n_fail++;
    end
    rd_n = 1'b1; tick(5);
  endtask

  task automatic test_simultaneous;
    int w0, r0, p0;
    logic [7:0] v;
    bus_addr(8'h21);
    w0 = wr_cnt; r0 = rd_cnt; p0 = pe_cnt;
    ad_sel = 1'b1; ad_in = 8'h77; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; wr_n = 1'b0; tick(8);
    n_tests++;
    if (ad_oe !== 1'b0 || pe_cnt - p0 !== 1) begin
      $display("FAIL sim_low: got oe %b pe %0d want 0 1", ad_oe, pe_cnt - p0); n_fail++;
    end
    rd_n = 1'b1; wr_n = 1'b1; tick(6);
    cs_n = 1'b1; tick(5);
    peek(6'h21, v);
    n_tests++;
    if (pe_cnt - p0 !== 1 || wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || v !== 8'h59) begin
      $display("FAIL sim_release: got pe %0d wr %0d rd %0d reg %h want 1 0 0 59",
               pe_cnt - p0, wr_cnt - w0, rd_cnt - r0, v); n_fail++;
    end
  endtask

  task automatic test_rd_in_addr_phase;
    int r0, p0;
    r0 = rd_cnt; p0 = pe_cnt;
    ad_sel = 1'b0; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(6);
    n_tests++;
    if (ad_oe !== 1'b0 || pe_cnt - p0 !== 1) begin
      $display("FAIL rdaddr: got oe %b pe %0d want 0 1", ad_oe, pe_cnt - p0); n_fail++;
    end
    rd_n = 1'b1; tick(5);
    cs_n = 1'b1; tick(5);
    n_tests++;
    if (rd_cnt - r0 !== 0) begin $display("FAIL rdaddr_done: got %0d want 0", rd_cnt - r0); n_fail++; end
  endtask

  task automatic test_reset_mid_read;
    int w0, p0, nz;
    ad_sel = 1'b1; cs_n = 1'b0; tick(5);
    rd_n = 1'b0; tick(5);
    n_tests++;
    if (ad_oe !== 1'b1) begin $display("FAIL rstrd_pre: got oe %b want 1", ad_oe); n_fail++; end
    reset = 1'b1; tick(1);
    n_tests++;
    if (ad_oe !== 1'b0) begin $display("FAIL rstrd_oe: got %b want 0", ad_oe); n_fail++; end
    rd_n = 1'b1; cs_n = 1'b1; tick(3);
    reset = 1'b0; tick(3);
    w0 = wr_cnt; p0 = pe_cnt;
    bus_write(8'h44);
    count_nonzero(nz);
    n_tests++;
    if (nz !== 0) begin $display("FAIL rstrd_regs: got %0d nonzero want 0", nz); n_fail++; end
    n_tests++;
    if (pe_cnt - p0 !== 1 || wr_cnt - w0 !== 0) begin
      $display("FAIL rstrd_write: got pe %0d wr %0d want 1 0", pe_cnt - p0, wr_cnt - w0); n_fail++;
    end
  endtask

  task automatic test_pulse_width;
    n_tests++;
    if (stretch_cnt !== 0) begin $display("FAIL pulse_width: got %0d stretched want 0", stretch_cnt); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_write_no_addr();
    test_write_read();
    test_wr_in_read();
    test_back_to_back();
    test_out_of_range();
    test_cs_release_mid_read();
    test_simultaneous();
    test_rd_in_addr_phase();
    test_reset_mid_read();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
